// File: rtl/mc_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and a single memory port with a req/ready handshake.
// Optional build macro: ILLEGAL_OP_TRAP_EN (unknown opcodes park the FSM in TRAP).
module mc_controller #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       instr_done,
   output logic       bus_err,
   output logic       illegal_instr
);

   typedef enum logic [3:0] {
      StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
      StExecR, StExecI, StJal, StAluWb, StBeq, StTrap
   } state_e;

   localparam logic [6:0] OpLw  = 7'b0000011;
   localparam logic [6:0] OpSw  = 7'b0100011;
   localparam logic [6:0] OpR   = 7'b0110011;
   localparam logic [6:0] OpI   = 7'b0010011;
   localparam logic [6:0] OpBeq = 7'b1100011;
   localparam logic [6:0] OpJal = 7'b1101111;

   // Counter must hold the limit value itself; limit cycle is judged on cnt_q == Limit.
   localparam int CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CntW-1:0] Limit = CntW'(MEM_TIMEOUT);

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            bus_err_q;
   logic [1:0]      alu_op;
   logic            pc_update, branch, req_raw, timeout;

   // State, timeout counter and sticky bus error register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StFetch;
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bus_err_q <= bus_err_q | timeout;
      end
   end

`ifdef ILLEGAL_OP_TRAP_EN
   logic illegal_q;

   // Sticky illegal-instruction flag, set on entry to TRAP
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) illegal_q <= 1'b0;
      else          illegal_q <= illegal_q | (state_d == StTrap);
   end

   assign illegal_instr = illegal_q;
`else
   assign illegal_instr = 1'b0;
`endif

   assign bus_err = bus_err_q;

   // Immediate format follows the opcode regardless of state
   always_comb begin
      ImmSrc = 2'b00;
      if (op == OpSw)       ImmSrc = 2'b01;
      else if (op == OpBeq) ImmSrc = 2'b10;
      else if (op == OpJal) ImmSrc = 2'b11;
   end

   // Next state, control outputs, timeout detection and counter update
   always_comb begin
      state_d    = state_q;
      req_raw    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      instr_done = 1'b0;
      alu_op     = 2'b00;
      pc_update  = 1'b0;
      branch     = 1'b0;

      case (state_q)
         StFetch: begin
            req_raw   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            if (mem_ready) begin
               IRWrite   = 1'b1;
               pc_update = 1'b1;
               state_d   = StDecode;
            end
         end
         StDecode: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            if (op == OpLw || op == OpSw) state_d = StMemAdr;
            else if (op == OpR)           state_d = StExecR;
            else if (op == OpI)           state_d = StExecI;
            else if (op == OpBeq)         state_d = StBeq;
            else if (op == OpJal)         state_d = StJal;
            else begin
`ifdef ILLEGAL_OP_TRAP_EN
               state_d = StTrap;
`else
               instr_done = 1'b1;
               state_d    = StFetch;
`endif
            end
         end
         StMemAdr: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            state_d = (op == OpLw) ? StMemRead : StMemWrite;
         end
         StMemRead: begin
            req_raw = 1'b1;
            AdrSrc  = 1'b1;
            if (mem_ready) state_d = StMemWb;
         end
         StMemWb: begin
            ResultSrc  = 2'b01;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = StFetch;
         end
         StMemWrite: begin
            req_raw  = 1'b1;
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               state_d    = StFetch;
            end
         end
         StExecR: begin
            ALUSrcA = 2'b10;
            alu_op  = 2'b10;
            state_d = StAluWb;
         end
         StExecI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            alu_op  = 2'b10;
            state_d = StAluWb;
         end
         StJal: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pc_update = 1'b1;
            state_d   = StAluWb;
         end
         StAluWb: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = StFetch;
         end
         StBeq: begin
            ALUSrcA    = 2'b10;
            alu_op     = 2'b01;
            branch     = 1'b1;
            instr_done = 1'b1;
            state_d    = StFetch;
         end
         StTrap: state_d = StTrap;
         default: state_d = StFetch;
      endcase

      // A ready arriving in the limit cycle still completes the access
      timeout = (MEM_TIMEOUT != 0) && req_raw && !mem_ready && (cnt_q == Limit);
      mem_req = req_raw;
      PCWrite = pc_update | (branch & zero);

      if (timeout) begin
         mem_req    = 1'b0;
         MemWrite   = 1'b0;
         IRWrite    = 1'b0;
         PCWrite    = 1'b0;
         RegWrite   = 1'b0;
         instr_done = 1'b0;
         state_d    = StFetch;
      end

      if (req_raw && !mem_ready && !timeout && (state_d == state_q)) cnt_d = cnt_q + CntW'(1);
      else                                                           cnt_d = '0;

      // Reset holds state at FETCH, whose request must not leak out
      if (!reset_n) begin
         mem_req    = 1'b0;
         MemWrite   = 1'b0;
         IRWrite    = 1'b0;
         PCWrite    = 1'b0;
         RegWrite   = 1'b0;
         instr_done = 1'b0;
      end
   end

   // ALU operation decode from the internal ALUOp
   always_comb begin
      ALUControl = 3'b000;
      case (alu_op)
         2'b01: ALUControl = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default: ALUControl = 3'b000;
      endcase
   end

endmodule
